port_uart_tx: RTL and testbench

- Device-side UART transmitter attached to one CPU memory-mapped port pair: the port output register acts as the command word, and the port input acts as the status word.
- The CPU requests a byte by writing data plus a flipped request-toggle bit; the block queues the byte in a small FIFO and serialises it 8N1 on txd.
- Status (ack toggle, full, busy, level) is returned combinationally-from-registers on the port input word, so software can poll with plain word loads.

---
 rtl/port_uart_tx.sv | 264 ++++++++++++++++++++++++++
 tb/tb_port_uart_tx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/port_uart_tx.sv
// port_uart_tx: memory-mapped-port UART transmitter.
// The CPU writes {toggle, data} on portOutput to request a byte. Accepted
// bytes are queued in a small circular FIFO and sent as serial frames on txd:
// a start bit, eight data bits LSB first, and a stop bit.
// portInput returns registered status: [8] ack toggle, [9] full, [10] busy,
// [11 +: FIFO_DEPTH_LOG2+1] fill level.
// Optional build macro PORT_UART_TX_PARITY_EN adds an even-parity bit between
// the data and stop bits, and sets portInput[15] as a capability flag.
module port_uart_tx #(
  parameter int CLOCKS_PER_BIT  = 434,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] portOutput,
  output logic [31:0] portInput,
  output logic        txd
);

  localparam int DEPTH   = 1 << FIFO_DEPTH_LOG2;
  localparam int LEVEL_W = FIFO_DEPTH_LOG2 + 1;
  localparam int BAUD_W  = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;

  localparam logic [BAUD_W-1:0]  BAUD_LAST  = BAUD_W'(CLOCKS_PER_BIT - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(DEPTH);

`ifdef PORT_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } txState_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } txState_t;
`endif

  // Serialiser state
  txState_t          state;
  txState_t          stateNext;
  logic [BAUD_W-1:0] baudCnt;
  logic [BAUD_W-1:0] baudNext;
  logic [2:0]        bitCnt;
  logic [2:0]        bitNext;
  logic [7:0]        shiftReg;
  logic              baudWrap;
  logic              txdNext;
  logic              popEn;
`ifdef PORT_UART_TX_PARITY_EN
  logic              parityReg;
`endif

  // FIFO storage and bookkeeping
  logic [7:0]                 fifoMem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wrPtr;
  logic [FIFO_DEPTH_LOG2-1:0] rdPtr;
  logic [LEVEL_W-1:0]         level;
  logic [7:0]                 fifoHead;
  logic                       fifoFull;
  logic                       fifoEmpty;
  logic                       pushEn;

  // Request handshake
  logic reqSeen;
  logic ackToggle;
  logic reqPending;

  // Status word
  logic        busy;
  logic [31:0] statusNext;

  // The upper command bits carry no meaning for this device.
  logic unusedCmdBits;
  assign unusedCmdBits = ^portOutput[31:9];

  assign fifoHead  = fifoMem[rdPtr];
  assign fifoFull  = (level == LEVEL_FULL);
  assign fifoEmpty = (level == '0);
  assign baudWrap  = (baudCnt == BAUD_LAST);

  // A flipped toggle is a new request; accept it when there is room, which
  // includes the cycle a pop frees the last slot.
  assign reqPending = portOutput[8] ^ reqSeen;
  assign pushEn     = reqPending && (!fifoFull || popEn);

  assign busy = (state != IDLE) || !fifoEmpty;

  // Next-state, bit timing and line value for the frame serialiser.
  always_comb begin
    stateNext = state;
    baudNext  = baudCnt;
    bitNext   = bitCnt;
    popEn     = 1'b0;
    txdNext   = 1'b1;
    case (state)
      IDLE: begin
        txdNext = 1'b1;
        if (!fifoEmpty) begin
          popEn     = 1'b1;
          baudNext  = '0;
          bitNext   = '0;
          stateNext = START;
        end
      end
      START: begin
        txdNext = 1'b0;
        if (baudWrap) begin
          baudNext  = '0;
          bitNext   = '0;
          stateNext = DATA;
        end else begin
          baudNext = baudCnt + 1'b1;
        end
      end
      DATA: begin
        txdNext = shiftReg[bitCnt];
        if (baudWrap) begin
          baudNext = '0;
          if (bitCnt == 3'd7) begin
`ifdef PORT_UART_TX_PARITY_EN
            stateNext = PARITY;
`else
            stateNext = STOP;
`endif
          end else begin
            bitNext = bitCnt + 3'd1;
          end
        end else begin
          baudNext = baudCnt + 1'b1;
        end
      end
`ifdef PORT_UART_TX_PARITY_EN
      PARITY: begin
        txdNext = parityReg;
        if (baudWrap) begin
          baudNext  = '0;
          stateNext = STOP;
        end else begin
          baudNext = baudCnt + 1'b1;
        end
      end
`endif
      STOP: begin
        txdNext = 1'b1;
        if (baudWrap) begin
          baudNext = '0;
          bitNext  = '0;
          if (!fifoEmpty) begin
            popEn     = 1'b1;
            stateNext = START;
          end else begin
            stateNext = IDLE;
          end
        end else begin
          baudNext = baudCnt + 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
        baudNext  = '0;
        bitNext   = '0;
      end
    endcase
  end

  // Serialiser registers; the FIFO head is captured whenever a frame starts.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baudCnt  <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
`ifdef PORT_UART_TX_PARITY_EN
      parityReg <= 1'b0;
`endif
    end else begin
      state   <= stateNext;
      baudCnt <= baudNext;
      bitCnt  <= bitNext;
      if (popEn) begin
        shiftReg <= fifoHead;
`ifdef PORT_UART_TX_PARITY_EN
        parityReg <= ^fifoHead;
`endif
      end
    end
  end

  // Registered line driver, so a frame aborted by reset returns to idle-high at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      txd <= 1'b1;
    end else begin
      txd <= txdNext;
    end
  end

  // FIFO data array; contents need no reset because the level gates every read.
  always_ff @(posedge clock) begin
    if (pushEn) begin
      fifoMem[wrPtr] <= portOutput[7:0];
    end
  end

  // FIFO pointers wrap naturally at the depth; level tracks push/pop together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (pushEn) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (popEn) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({pushEn, popEn})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // One accepted byte per toggle edge: remember the toggle and echo it as the ack.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      reqSeen   <= 1'b0;
      ackToggle <= 1'b0;
    end else if (pushEn) begin
      reqSeen   <= portOutput[8];
      ackToggle <= ~ackToggle;
    end
  end

  // Assemble the status word from internal registers only.
  always_comb begin
    statusNext                 = '0;
    statusNext[8]              = ackToggle;
    statusNext[9]              = fifoFull;
    statusNext[10]             = busy;
    statusNext[11 +: LEVEL_W]  = level;
`ifdef PORT_UART_TX_PARITY_EN
    statusNext[15]             = 1'b1;
`endif
  end

  // Status is registered so software never sees a path from portOutput.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      portInput <= '0;
    end else begin
      portInput <= statusNext;
    end
  end

endmodule

// File: tb/tb_port_uart_tx.sv
// tb_port_uart_tx: directed bench for port_uart_tx with CLOCKS_PER_BIT=4 and a
// four-entry FIFO. A line monitor decodes txd frames so byte order, stop bits
// and frame spacing can be compared against hand-computed values.
// Builds with or without PORT_UART_TX_PARITY_EN.
module tb_port_uart_tx;

  localparam int CPB  = 4;
  localparam int LOG2 = 2;
`ifdef PORT_UART_TX_PARITY_EN
  localparam int          FRAME_BITS = 11;
  localparam logic [31:0] CAP        = 32'h0000_8000;
  localparam logic [10:0] FRAME_55   = 11'b1_0_01010101_0;
`else
  localparam int          FRAME_BITS = 10;
  localparam logic [31:0] CAP        = 32'h0000_0000;
  localparam logic [9:0]  FRAME_55   = 10'b1_01010101_0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] portOutput = 32'h0;
  logic [31:0] portInput;
  logic        txd;

  int tests    = 0;
  int failures = 0;
  int cycle    = 0;

  // Line monitor state
  logic       rxBusy = 1'b0;
  int         rxCnt = 0;
  int         rxCount = 0;
  int         rxStartNow = 0;
  logic [7:0] rxShift = 8'h00;
  logic       rxPar = 1'b0;
  logic [7:0] rxBytes  [32];
  int         rxStart  [32];
  logic       rxStop   [32];
  logic       rxParity [32];

  logic tog;
  int   base;
  logic [FRAME_BITS-1:0] expFrame;

  port_uart_tx #(
    .CLOCKS_PER_BIT (CPB),
    .FIFO_DEPTH_LOG2(LOG2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .portOutput(portOutput),
    .portInput (portInput),
    .txd       (txd)
  );

  // Free-running clock and cycle count
  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  // Decode frames on txd, sampling each bit in its middle.
  always @(negedge clock) begin
    if (!reset) begin
      rxBusy = 1'b0;
      rxCnt  = 0;
    end else if (!rxBusy) begin
      if (txd === 1'b0) begin
        rxBusy     = 1'b1;
        rxCnt      = 0;
        rxStartNow = cycle;
      end
    end else begin
      rxCnt = rxCnt + 1;
      if ((rxCnt % CPB) == (CPB / 2)) begin
        if ((rxCnt / CPB) >= 1 && (rxCnt / CPB) <= 8) begin
          rxShift[(rxCnt / CPB) - 1] = txd;
        end
        if (FRAME_BITS == 11 && (rxCnt / CPB) == 9) begin
          rxPar = txd;
        end
        if ((rxCnt / CPB) == FRAME_BITS - 1) begin
          if (rxCount < 32) begin
            rxBytes[rxCount]  = rxShift;
            rxStart[rxCount]  = rxStartNow;
            rxStop[rxCount]   = txd;
            rxParity[rxCount] = rxPar;
          end
          rxCount = rxCount + 1;
          rxBusy  = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic toggle);
    @(negedge clock);
    portOutput = {23'd0, toggle, data};
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic waitAck(input logic expected, input string tag, input int bound);
    int n = 0;
    while (portInput[8] !== expected && n < bound) begin
      @(negedge clock);
      n++;
    end
    checkOutput(tag, {31'd0, portInput[8]}, {31'd0, expected});
  endtask

  // Global time limit
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    reset      = 1'b0;
    portOutput = 32'h0;
    waitCycles(5);
    checkOutput("resetTxd", {31'd0, txd}, 32'd1);
    checkOutput("resetStatus", portInput, 32'h0);
    reset = 1'b1;
    waitCycles(20);
    checkOutput("idleTxd", {31'd0, txd}, 32'd1);
    checkOutput("idleStatus", portInput, CAP);
    checkOutput("idleNoFrame", rxCount, 0);

    // Single byte 0x55 with exact bit timing
    expFrame = FRAME_55;
    applyStimulus(8'h55, 1'b1);
    waitCycles(2);
    checkOutput("singleAckStatus", portInput, 32'h0000_0D00 | CAP);
    checkOutput("singlePreStart", {31'd0, txd}, 32'd1);
    waitCycles(1);
    checkOutput("singleStartEdge", {31'd0, txd}, 32'd0);
    for (int i = 0; i < FRAME_BITS; i++) begin
      waitCycles(i == 0 ? 1 : CPB);
      checkOutput($sformatf("singleBit%0d", i), {31'd0, txd}, {31'd0, expFrame[i]});
    end
    waitCycles(2);
    checkOutput("singleBusyLast", {31'd0, portInput[10]}, 32'd1);
    waitCycles(1);
    checkOutput("singleBusyDrop", portInput, 32'h0000_0100 | CAP);
    checkOutput("singleRxByte", {24'd0, rxBytes[0]}, 32'h55);

    // Burst: six bytes, the sixth waits for a pop while the FIFO is full
    base = rxCount;
    tog  = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tog = ~tog;
      applyStimulus(8'(k), tog);
      waitAck(tog, $sformatf("burstAck%0d", k), 20);
    end
    tog = ~tog;
    applyStimulus(8'h06, tog);
    waitCycles(3);
    checkOutput("burstFull", {31'd0, portInput[9]}, 32'd1);
    checkOutput("burstAckHeld", {31'd0, portInput[8]}, {31'd0, ~tog});
    waitAck(tog, "burstAckLate", 80);
    checkOutput("burstFullAfterSwap", {31'd0, portInput[9]}, 32'd1);
    checkOutput("burstLevelAfterSwap", {29'd0, portInput[13:11]}, 32'd4);
    for (int n = 0; n < 600 && rxCount < base + 6; n++) @(negedge clock);
    checkOutput("burstCount", rxCount - base, 6);
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("burstByte%0d", k + 1), {24'd0, rxBytes[base + k]}, k + 1);
      checkOutput($sformatf("burstStop%0d", k + 1), {31'd0, rxStop[base + k]}, 32'd1);
    end
    for (int k = 1; k < 6; k++) begin
      checkOutput($sformatf("burstGap%0d", k), rxStart[base + k] - rxStart[base + k - 1],
                  FRAME_BITS * CPB);
    end

    // Held toggle with changing data: exactly one byte
    waitCycles(10);
    base = rxCount;
    tog  = ~tog;
    applyStimulus(8'hA3, tog);
    waitAck(tog, "heldAck", 20);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      portOutput = {23'd0, tog, 8'(i)};
    end
    waitCycles(60);
    checkOutput("heldCount", rxCount - base, 1);
    checkOutput("heldByte", {24'd0, rxBytes[base]}, 32'hA3);
    checkOutput("heldIdle", portInput, CAP);

    // Reset during data bit 3 of 0xC3 with one more byte queued
    base = rxCount;
    tog  = ~tog;
    applyStimulus(8'hC3, tog);
    waitAck(tog, "midAckFirst", 20);
    tog = ~tog;
    applyStimulus(8'h11, tog);
    waitAck(tog, "midAckSecond", 20);
    for (int n = 0; n < 200 && !(rxBusy && rxCnt == 4 * CPB + CPB / 2); n++) @(negedge clock);
    checkOutput("midReachedBit3", {31'd0, rxBusy}, 32'd1);
    checkOutput("midTxdBit3", {31'd0, txd}, 32'd0);
    reset      = 1'b0;
    portOutput = 32'h0;
    #1;
    checkOutput("midResetTxd", {31'd0, txd}, 32'd1);
    checkOutput("midResetStatus", portInput, 32'h0);
    waitCycles(3);
    reset = 1'b1;
    waitCycles(80);
    checkOutput("midNoResumeCount", rxCount - base, 0);
    checkOutput("midNoResumeBusy", {31'd0, rxBusy}, 32'd0);
    checkOutput("midNoResumeStatus", portInput, CAP);
    checkOutput("midNoResumeTxd", {31'd0, txd}, 32'd1);

`ifdef PORT_UART_TX_PARITY_EN
    // Parity: 0x07 has three ones, so the even-parity bit is 1
    base = rxCount;
    applyStimulus(8'h07, 1'b1);
    waitAck(1'b1, "parityAck", 20);
    checkOutput("parityCapFlag", {31'd0, portInput[15]}, 32'd1);
    for (int n = 0; n < 200 && rxCount < base + 1; n++) @(negedge clock);
    checkOutput("parityCount", rxCount - base, 1);
    checkOutput("parityByte", {24'd0, rxBytes[base]}, 32'h07);
    checkOutput("parityBit", {31'd0, rxParity[base]}, 32'd1);
    checkOutput("parityStop", {31'd0, rxStop[base]}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
